// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader
// Purpose : Boot loader that takes a byte stream (a word count, then
//           instruction words) and writes it into instruction BRAM.
// Rev     : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  s_dat,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] w_addr,
    output logic [31:0] w_dat,
    output logic        w_enb,
    output logic [3:0]  byte_enb,
    output logic        core_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [31:0] C_MAX_WORDS = 32'(MAX_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_asm;
    logic [31:0] r_len;
    logic [31:0] r_index;
    logic        w_accept;
    logic        w_last_byte;
    logic        w_clear;
    logic [31:0] w_word;

    assign s_ready     = (r_state == ST_LEN) || (r_state == ST_DATA);
    assign core_hold   = (r_state != ST_DONE);
    assign done        = (r_state == ST_DONE);
    assign err         = (r_state == ST_ERR);
    assign byte_enb    = w_enb ? 4'hF : 4'h0;
    assign w_accept    = s_valid && s_ready;
    assign w_last_byte = w_accept && (r_byte_cnt == 2'd3);
    // The fourth byte is used straight off the bus so the group slot is free next cycle.
    assign w_word      = {s_dat, r_asm};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_next  = ST_LEN;
                    w_clear = 1'b1;
                end
            end
            ST_LEN: begin
                if (w_last_byte) begin
                    if (w_word == 32'd0) begin
                        w_next = ST_DONE;
                    end else if (w_word > C_MAX_WORDS) begin
                        w_next = ST_ERR;
                    end else begin
                        w_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_last_byte && (r_index == r_len - 32'd1)) begin
                    w_next = ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_cnt <= 2'd0;
            r_asm      <= 24'd0;
            r_len      <= 32'd0;
            r_index    <= 32'd0;
            w_enb      <= 1'b0;
            w_addr     <= BASE_ADDR;
            w_dat      <= 32'd0;
        end else begin
            w_enb <= 1'b0;
            if (w_clear) begin
                r_byte_cnt <= 2'd0;
                r_asm      <= 24'd0;
                r_len      <= 32'd0;
                r_index    <= 32'd0;
            end else if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                case (r_byte_cnt)
                    2'd0:    r_asm[7:0]   <= s_dat;
                    2'd1:    r_asm[15:8]  <= s_dat;
                    2'd2:    r_asm[23:16] <= s_dat;
                    default: begin
                        if (r_state == ST_LEN) begin
                            r_len <= w_word;
                        end else begin
                            w_enb   <= 1'b1;
                            w_dat   <= w_word;
                            w_addr  <= BASE_ADDR + (r_index << 2);
                            r_index <= r_index + 32'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_loader
// Purpose : Directed bench with a stream-level reference model for imem_loader.
// Rev     : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_dat = 8'h00;
    logic        s_ready;
    logic [31:0] w_addr;
    logic [31:0] w_dat;
    logic        w_enb;
    logic [3:0]  byte_enb;
    logic        core_hold;
    logic        done;
    logic        err;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .start(start), .s_dat(s_dat), .s_valid(s_valid),
        .s_ready(s_ready), .w_addr(w_addr), .w_dat(w_dat), .w_enb(w_enb),
        .byte_enb(byte_enb), .core_hold(core_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    // Reference model: interprets the accepted byte stream as count + words.
    typedef enum int {M_IDLE, M_LOAD, M_DONE, M_ERR} mphase_t;
    mphase_t     m_phase = M_IDLE;
    logic [7:0]  m_bytes[$];
    logic [31:0] m_n = 32'd0;
    logic        exp_wenb = 1'b0;
    logic [31:0] exp_addr = BASE;
    logic [31:0] exp_dat = 32'd0;

    always @(posedge clk or negedge rst) begin : model
        int nb;
        int idx;
        if (!rst) begin
            m_phase = M_IDLE;
            m_bytes.delete();
            exp_wenb = 1'b0;
        end else begin
            exp_wenb = 1'b0;
            if (m_phase == M_LOAD) begin
                if (s_valid) begin
                    m_bytes.push_back(s_dat);
                    nb = m_bytes.size();
                    if (nb == 4) begin
                        m_n = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                        if (m_n == 32'd0)             m_phase = M_DONE;
                        else if (m_n > 32'(MAXW))     m_phase = M_ERR;
                    end else if (nb % 4 == 0) begin
                        idx      = nb / 4 - 2;
                        exp_wenb = 1'b1;
                        exp_addr = BASE + 32'(4 * idx);
                        exp_dat  = {m_bytes[nb-1], m_bytes[nb-2], m_bytes[nb-3], m_bytes[nb-4]};
                        if (32'(idx) == m_n - 32'd1) m_phase = M_DONE;
                    end
                end
            end else if (start) begin
                m_phase = M_LOAD;
                m_bytes.delete();
            end
        end
    end

    logic [63:0] act_log[$];

    always @(negedge clk) begin
        check("s_ready",   32'(s_ready),   32'(m_phase == M_LOAD));
        check("core_hold", 32'(core_hold), 32'(m_phase != M_DONE));
        check("done",      32'(done),      32'(m_phase == M_DONE));
        check("err",       32'(err),       32'(m_phase == M_ERR));
        check("w_enb",     32'(w_enb),     32'(exp_wenb));
        check("byte_enb",  32'(byte_enb),  exp_wenb ? 32'hF : 32'h0);
        if (exp_wenb) begin
            check("w_addr", w_addr, exp_addr);
            check("w_dat",  w_dat,  exp_dat);
        end
        if (w_enb) act_log.push_back({w_addr, w_dat});
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input logic st);
        repeat (gap) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_dat   = b;
        start   = st;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_log(input string name, input int i, input logic [31:0] a, input logic [31:0] d);
        if (i < act_log.size()) begin
            check({name, "_addr"}, act_log[i][63:32], a);
            check({name, "_dat"},  act_log[i][31:0],  d);
        end else begin
            check({name, "_missing"}, 32'(act_log.size()), 32'(i + 1));
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_w_addr",    w_addr, BASE);
        check("rst_w_dat",     w_dat, 32'd0);
        check("rst_core_hold", 32'(core_hold), 32'd1);
        check("rst_s_ready",   32'(s_ready), 32'd0);
        rst = 1'b1;
        idle(2);

        // Single word load
        act_log.delete();
        pulse_start();
        send_word(32'd1, 0);
        send_word(32'h00A00513, 0);
        idle(3);
        check("t1_count", 32'(act_log.size()), 32'd1);
        check_log("t1", 0, 32'h0, 32'h00A00513);
        check("t1_model_dat", exp_dat, 32'h00A00513);
        check("t1_done", 32'(done), 32'd1);
        check("t1_hold", 32'(core_hold), 32'd0);
        // Bytes offered while not ready are dropped
        send_byte(8'hAA, 0, 1'b0);
        send_byte(8'hBB, 0, 1'b0);
        idle(2);
        check("t1_drop_count", 32'(act_log.size()), 32'd1);

        // Three back-to-back words
        act_log.delete();
        pulse_start();
        send_word(32'd3, 0);
        send_word(32'h11223344, 0);
        send_word(32'hDEADBEEF, 0);
        send_word(32'h00000013, 0);
        idle(3);
        check("t2_count", 32'(act_log.size()), 32'd3);
        check_log("t2w0", 0, 32'h0, 32'h11223344);
        check_log("t2w1", 1, 32'h4, 32'hDEADBEEF);
        check_log("t2w2", 2, 32'h8, 32'h00000013);

        // Zero-length image
        act_log.delete();
        pulse_start();
        send_word(32'd0, 0);
        idle(3);
        check("t3_count", 32'(act_log.size()), 32'd0);
        check("t3_done", 32'(done), 32'd1);

        // Oversize image rejected, then recovery with start ignored mid-load
        act_log.delete();
        pulse_start();
        send_word(32'd1025, 0);
        idle(3);
        check("t4_err", 32'(err), 32'd1);
        check("t4_hold", 32'(core_hold), 32'd1);
        check("t4_ready", 32'(s_ready), 32'd0);
        check("t4_count", 32'(act_log.size()), 32'd0);
        pulse_start();
        send_word(32'd1, 0);
        send_byte(8'h0D, 0, 1'b0);
        send_byte(8'hF0, 0, 1'b0);
        send_byte(8'hFE, 0, 1'b1);
        send_byte(8'hCA, 0, 1'b0);
        idle(3);
        check("t4b_err", 32'(err), 32'd0);
        check("t4b_done", 32'(done), 32'd1);
        check("t4b_count", 32'(act_log.size()), 32'd1);
        check_log("t4b", 0, 32'h0, 32'hCAFEF00D);

        // Stalled stream with random gaps
        act_log.delete();
        pulse_start();
        send_word(32'd2, 2);
        send_word(32'h00500093, 3);
        send_word(32'h00108113, 3);
        idle(3);
        check("t5_count", 32'(act_log.size()), 32'd2);
        check_log("t5w0", 0, 32'h0, 32'h00500093);
        check_log("t5w1", 1, 32'h4, 32'h00108113);

        // Reset in the middle of the second word
        act_log.delete();
        pulse_start();
        send_word(32'd2, 0);
        send_word(32'h12345678, 0);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        s_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("t6_hold_async", 32'(core_hold), 32'd1);
        check("t6_ready_async", 32'(s_ready), 32'd0);
        @(negedge clk);
        check("t6_done", 32'(done), 32'd0);
        rst = 1'b1;
        idle(1);
        pulse_start();
        send_word(32'd1, 0);
        send_word(32'h0000006F, 0);
        idle(3);
        check("t6_count", 32'(act_log.size()), 32'd2);
        check_log("t6w0", 0, 32'h0, 32'h12345678);
        check_log("t6w1", 1, 32'h0, 32'h0000006F);
        check("t6_done_after", 32'(done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
